// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  localparam logic [INSTR_W-1:0] ZERO_INSTR = '0;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch-side bus: instruction memory port, redirect request and the decode handshake.
interface fetch_if;
  import fetch_pkg::*;

  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               halted;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, halted,
    input  imem_instr, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, halted,
    output imem_instr, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry prefetch FIFO of {pc, instr} with flush; head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     din,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = (count != '0) ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; the count gates every read, so stale entries are never visible.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: PC register, RUN/HALT state, redirect handling and prefetch queue.
// Optional stop-at-zero-word behaviour is enabled by defining FETCH_HALT_ON_ZERO_EN.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int              DEPTH    = 2
) (
  input logic     clk,
  input logic     rst,
  fetch_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PC_W-1:0]  pc;
  fetch_state_t     state;
  fetch_entry_t     head;
  fetch_entry_t     din;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             can_push;
  logic             fetch_go;
  logic             zero_hit;
  logic             push;

  assign pop      = (count != '0) && bus.out_ready;
  assign can_push = (count != CNT_W'(DEPTH)) || pop;
  assign fetch_go = can_push && !bus.redirect_valid && (state == RUN);

`ifdef FETCH_HALT_ON_ZERO_EN
  assign zero_hit   = fetch_go && (bus.imem_instr == ZERO_INSTR);
  assign bus.halted = (state == HALT);
`else
  assign zero_hit   = 1'b0;
  assign bus.halted = 1'b0;
`endif

  assign push = fetch_go && !zero_hit;
  assign din  = '{pc: pc, instr: bus.imem_instr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc    <= RESET_PC;
      state <= RUN;
    end else if (bus.redirect_valid) begin
      pc    <= align_pc(bus.redirect_pc);
      state <= RUN;
    end else if (push) begin
      pc <= pc + PC_STEP;
    end else if (zero_hit) begin
      // pc stays on the zero word so a later inspection sees where the program ended
      state <= HALT;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect_valid),
    .din   (din),
    .head  (head),
    .count (count)
  );

  assign bus.imem_addr = pc;
  assign bus.out_valid = (count != '0);
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;

endmodule
